ped_button_conditioner: RTL and testbench
=========================================

// Module: ped_button_conditioner
// PURPOSE
// Front end for the two pedestrian push-buttons that feed traffic_light_top.
// Synchronises the raw active-low buttons (nrth/west), debounces them, and holds
// a sticky crossing request per direction until the light controller acknowledges
// the walk phase. Sits between the board pins and the controller's request inputs.
// PARAMETERS
// DEBOUNCE_CYCLES  1000000  consecutive stable samples to accept an edge (20 ms @ 50 MHz); min 2
// CNT_W            20       debounce counter width; must hold DEBOUNCE_CYCLES-1
// SYNC_STAGES      2        synchroniser depth per button; min 2
// PORTS
// clk_50_mhz        in   1  system clock, 50 MHz
// reset_n           in   1  asynchronous, active-low reset
// nrth_ped_button   in   1  raw north button, active-low (0 = pressed), asynchronous
// west_ped_button   in   1  raw west button, active-low, asynchronous
// nrth_walk_ack     in   1  1-cycle pulse from controller: north walk phase started
// west_walk_ack     in   1  1-cycle pulse from controller: west walk phase started
// nrth_ped_req      out  1  sticky north crossing request, active-high
// west_ped_req      out  1  sticky west crossing request, active-high
// nrth_press_pulse  out  1  1-cycle pulse per accepted north press
// west_press_pulse  out  1  1-cycle pulse per accepted west press
// debug_nrth_held   out  1  debounced north level (1 = held)
// debug_west_held   out  1  debounced west level (1 = held)
// BEHAVIOUR
// - Reset (reset_n=0, async): sync flops = 1 (released), FSM = IDLE, counters = 0;
//   all outputs 0. Release of reset is sampled synchronously; no output change
//   until a button is seen low after reset.
// - Channels nrth/west are identical and fully independent; no shared state.
// - Sync: SYNC_STAGES flops; FSM sees only the last stage (btn_s).
// - Debounce FSM per channel, counter cleared on every state change:
//   IDLE:         btn_s=0 -> PRESS_WAIT.
//   PRESS_WAIT:   btn_s=1 -> IDLE (glitch rejected, no pulse);
//                 btn_s=0 -> count++; at DEBOUNCE_CYCLES consecutive low samples -> HELD.
//   HELD:         btn_s=1 -> RELEASE_WAIT. held output = 1 in HELD and RELEASE_WAIT.
//   RELEASE_WAIT: btn_s=0 -> HELD (no new pulse);
//                 btn_s=1 for DEBOUNCE_CYCLES consecutive samples -> IDLE.
// - Entry into HELD: press_pulse = 1 for exactly that cycle; ped_req set on the same edge.
// - Press latency: press_pulse/ped_req rise exactly SYNC_STAGES+DEBOUNCE_CYCLES edges
//   after the first edge that samples the raw button low (held low throughout).
// - One pulse per physical press; holding the button never re-pulses or auto-repeats.
// - ped_req: set by press_pulse, cleared on the edge after walk_ack. Same-cycle
//   press_pulse and walk_ack: set wins (req stays 1; press was not served).
//   walk_ack with req=0: no effect. Repeated presses while req=1: req stays 1, pulses still issue.
// - Counter saturates by construction (state exits at terminal count); no wrap.
// - Reset mid-debounce or with req=1: everything returns to reset values at once; a
//   button still held at reset release must pass a full debounce to register.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
// 1 Reset: reset_n=0 with buttons toggling -> all outputs 0; after release, buttons=1 -> outputs stay 0.
// 2 Clean press: nrth low at edge N, held 10 cycles -> nrth_press_pulse=1 only at edge N+6,
//   nrth_ped_req=1 from N+6; debug_nrth_held=1; west outputs stay 0.
// 3 Glitch: west low for 3 cycles then high -> no west_press_pulse, west_ped_req stays 0.
// 4 Bounce: nrth low 2/high 1/low 8 cycles -> exactly one pulse; release bounce high 2/low 1/high 8
//   -> no extra pulse; debug_nrth_held falls 4 sampled-high cycles after last low.
// 5 Ack: req=1, nrth_walk_ack pulse -> req 0 next edge; ack coincident with new press_pulse
//   -> req stays 1.
// 6 Reset mid-op: assert reset_n=0 during PRESS_WAIT and with west_ped_req=1 -> all outputs 0
//   immediately (async); held button after release re-pulses after 6 edges.

Source files
------------

// File: rtl/ped_button_conditioner_if.sv
// Pedestrian button bundle between the board pins / light controller and the conditioner.
// The master side drives raw buttons and walk acks; the slave side returns requests and debug levels.
interface ped_button_conditioner_if;
    logic nrth_ped_button;
    logic west_ped_button;
    logic nrth_walk_ack;
    logic west_walk_ack;
    logic nrth_ped_req;
    logic west_ped_req;
    logic nrth_press_pulse;
    logic west_press_pulse;
    logic debug_nrth_held;
    logic debug_west_held;

    modport master (
        output nrth_ped_button, west_ped_button, nrth_walk_ack, west_walk_ack,
        input  nrth_ped_req, west_ped_req, nrth_press_pulse, west_press_pulse,
        input  debug_nrth_held, debug_west_held
    );

    modport slave (
        input  nrth_ped_button, west_ped_button, nrth_walk_ack, west_walk_ack,
        output nrth_ped_req, west_ped_req, nrth_press_pulse, west_press_pulse,
        output debug_nrth_held, debug_west_held
    );
endinterface

// File: rtl/ped_button_conditioner.sv
// Synchronises, debounces and latches the two active-low pedestrian buttons into
// sticky crossing requests that are cleared by the light controller's walk acks.
module ped_button_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_50_mhz,
    input  logic reset_n,
    input  logic button,
    input  logic walk_ack,
    output logic ped_req,
    output logic press_pulse,
    output logic held
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;
    logic                   terminal;
    logic                   enter_held;

    // Synchroniser resets to "released" so a held button never registers without a full debounce.
    always_ff @(posedge clk_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], button};
        end
    end

    assign btn_s    = sync[SYNC_STAGES-1];
    assign terminal = (count == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            press_pulse <= 1'b0;
            ped_req     <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            press_pulse <= enter_held;
            ped_req     <= enter_held | (ped_req & ~walk_ack);
        end
    end

    // Counter restarts on every state change, so it can only reach the terminal value once per wait.
    always_comb begin
        state_next = state;
        count_next = count;
        enter_held = 1'b0;
        case (state)
            IDLE: begin
                if (!btn_s) begin
                    state_next = PRESS_WAIT;
                    count_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (btn_s) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (terminal) begin
                    state_next = HELD;
                    count_next = '0;
                    enter_held = 1'b1;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            HELD: begin
                if (btn_s) begin
                    state_next = RELEASE_WAIT;
                    count_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!btn_s) begin
                    state_next = HELD;
                    count_next = '0;
                end else if (terminal) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign held = (state == HELD) || (state == RELEASE_WAIT);
endmodule

module ped_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                      clk_50_mhz,
    input  logic                      reset_n,
    ped_button_conditioner_if.slave   bus
);
    ped_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .SYNC_STAGES     (SYNC_STAGES)
    ) nrth_channel (
        .clk_50_mhz  (clk_50_mhz),
        .reset_n     (reset_n),
        .button      (bus.nrth_ped_button),
        .walk_ack    (bus.nrth_walk_ack),
        .ped_req     (bus.nrth_ped_req),
        .press_pulse (bus.nrth_press_pulse),
        .held        (bus.debug_nrth_held)
    );

    ped_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .SYNC_STAGES     (SYNC_STAGES)
    ) west_channel (
        .clk_50_mhz  (clk_50_mhz),
        .reset_n     (reset_n),
        .button      (bus.west_ped_button),
        .walk_ack    (bus.west_walk_ack),
        .ped_req     (bus.west_ped_req),
        .press_pulse (bus.west_press_pulse),
        .held        (bus.debug_west_held)
    );
endmodule

// File: tb/tb_ped_button_conditioner.sv
// Self-checking bench: directed scenarios plus randomized button/ack traffic compared
// against a run-length reference model of the debounced button behaviour.
module tb_ped_button_conditioner;
    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int HIST = 8192;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   passes  = 0;

    // Reference model: raw button history per channel, run length of the synchronised level.
    bit hist[2][HIST];
    int edgeCount;
    int runLen[2];
    bit runLvl[2];
    bit mHeld[2];
    bit mPulse[2];
    bit mReq[2];

    ped_button_conditioner_if bus();

    ped_button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk_50_mhz (clk),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: actual %0d required %0d (t=%0t)", tag, actual, expected, $time);
    endtask

    function automatic void modelReset();
        edgeCount = 0;
        for (int c = 0; c < 2; c++) begin
            runLen[c] = 0;
            runLvl[c] = 1'b1;
            mHeld[c]  = 1'b0;
            mPulse[c] = 1'b0;
            mReq[c]   = 1'b0;
        end
    endfunction

    // A level change is accepted once the synchronised button shows DEB+1 equal samples in a row.
    function automatic void modelEdge(input bit nb, input bit wb, input bit na, input bit wa);
        bit raw[2];
        bit ack[2];
        bit s;
        raw[0] = nb; raw[1] = wb;
        ack[0] = na; ack[1] = wa;
        for (int c = 0; c < 2; c++) begin
            if (edgeCount < HIST) hist[c][edgeCount] = raw[c];
            s = (edgeCount >= SYNC && edgeCount - SYNC < HIST) ? hist[c][edgeCount - SYNC] : 1'b1;
            if (s == runLvl[c]) runLen[c]++;
            else begin
                runLvl[c] = s;
                runLen[c] = 1;
            end
            mPulse[c] = 1'b0;
            if (!mHeld[c] && s == 1'b0 && runLen[c] >= DEB + 1) begin
                mHeld[c]  = 1'b1;
                mPulse[c] = 1'b1;
            end else if (mHeld[c] && s == 1'b1 && runLen[c] >= DEB + 1) begin
                mHeld[c] = 1'b0;
            end
            if (mPulse[c]) mReq[c] = 1'b1;
            else if (ack[c]) mReq[c] = 1'b0;
        end
        edgeCount++;
    endfunction

    task automatic compareAll();
        checkOutput("nrth_ped_req",     bus.nrth_ped_req,     mReq[0]);
        checkOutput("west_ped_req",     bus.west_ped_req,     mReq[1]);
        checkOutput("nrth_press_pulse", bus.nrth_press_pulse, mPulse[0]);
        checkOutput("west_press_pulse", bus.west_press_pulse, mPulse[1]);
        checkOutput("debug_nrth_held",  bus.debug_nrth_held,  mHeld[0]);
        checkOutput("debug_west_held",  bus.debug_west_held,  mHeld[1]);
    endtask

    // One clock: drive inputs, step the model on the edge, compare 1 time unit later.
    task automatic applyStimulus(input bit nb, input bit wb, input bit na, input bit wa);
        bus.nrth_ped_button = nb;
        bus.west_ped_button = wb;
        bus.nrth_walk_ack   = na;
        bus.west_walk_ack   = wa;
        @(posedge clk);
        if (reset_n) modelEdge(nb, wb, na, wa);
        else modelReset();
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic asyncReset();
        #4;
        reset_n = 1'b0;
        #1;
        modelReset();
        compareAll();
    endtask

    initial begin
        int lat;
        int pulses;
        int fallIdx;
        int remN;
        int remW;
        bit lvN;
        bit lvW;
        bit seqN[22];

        bus.nrth_ped_button = 1'b1;
        bus.west_ped_button = 1'b1;
        bus.nrth_walk_ack   = 1'b0;
        bus.west_walk_ack   = 1'b0;
        modelReset();

        $display("[TB] reset with toggling buttons");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        reset_n = 1'b1;
        idleCycles(5);

        $display("[TB] clean north press");
        lat = -1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (bus.nrth_press_pulse) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        checkOutput("press_latency", lat, SYNC + DEB);
        checkOutput("press_pulse_count", pulses, 1);
        checkOutput("west_req_untouched", bus.west_ped_req, 0);
        idleCycles(10);

        $display("[TB] west glitch");
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, (i < 3) ? 1'b0 : 1'b1, 1'b0, 1'b0);
            if (bus.west_press_pulse) pulses++;
        end
        checkOutput("glitch_pulse_count", pulses, 0);
        checkOutput("glitch_west_req", bus.west_ped_req, 0);

        $display("[TB] north bounce on press and release");
        for (int i = 0; i < 22; i++)
            seqN[i] = !((i < 2) || (i >= 3 && i <= 10) || (i == 13));
        pulses = 0; fallIdx = -1;
        for (int i = 0; i < 22; i++) begin
            applyStimulus(seqN[i], 1'b1, 1'b0, 1'b0);
            if (bus.nrth_press_pulse) pulses++;
            if (i > 13 && !bus.debug_nrth_held && fallIdx < 0) fallIdx = i;
        end
        checkOutput("bounce_pulse_count", pulses, 1);
        checkOutput("release_fall_edge", fallIdx, 13 + 1 + SYNC + DEB);
        idleCycles(4);

        $display("[TB] walk acknowledge");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("ack_clears_req", bus.nrth_ped_req, 0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b1, (i == SYNC + DEB) ? 1'b1 : 1'b0, 1'b0);
        checkOutput("ack_vs_press_set_wins", bus.nrth_ped_req, 1);
        idleCycles(10);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(8);
        checkOutput("west_req_before_reset", bus.west_ped_req, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        asyncReset();
        checkOutput("async_reset_west_req", bus.west_ped_req, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b1;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (bus.nrth_press_pulse && lat < 0) lat = i;
        end
        checkOutput("post_reset_latency", lat, SYNC + DEB);
        idleCycles(10);

        $display("[TB] randomized traffic");
        remN = 0; remW = 0; lvN = 1'b1; lvW = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (remN == 0) begin
                lvN  = ~lvN;
                remN = lvN ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 10));
            end
            if (remW == 0) begin
                lvW  = ~lvW;
                remW = lvW ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 10));
            end
            remN--;
            remW--;
            applyStimulus(lvN, lvW, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
